alu_mul_seq: RTL and testbench

Multi-cycle 16-bit multiplier sequencer that reuses the Hack ALU (zx/nx/zy/ny/f/no control, 16-bit x/y/out, zr/ng flags) as its only arithmetic resource. It drives the ALU operands and control bits one micro-operation per cycle and captures alu_out/alu_zr at each clock edge. The ALU sits outside this block, so one ALU instance serves the multiply path. Product is the low 16 bits of a*b.

---
 rtl/alu_mul_seq.sv | 159 +++++++++++++++
 tb/tb_alu_mul_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 16-bit multiplier that borrows an external
// Hack ALU for all arithmetic, issuing one ALU micro-op per cycle.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start, a, b    request and operands (sampled when accepted in IDLE)
//   busy, done     busy outside IDLE; done is a one-cycle product-valid pulse
//   product        low WIDTH bits of a*b, held until the next accepted start
//   alu_x, alu_y   ALU operands
//   alu_zx..alu_no ALU control bits
//   alu_out,alu_zr ALU result and zero flag
//
// Build option: ALU_MUL_EARLY_EXIT_EN finishes as soon as the doubled
// multiplicand becomes zero.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_DBL_M,
    S_DBL_K,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_TEST;
      S_TEST:  state_d = alu_zr ? S_DBL_M : S_ADD;
      S_ADD:   state_d = S_DBL_M;
`ifdef ALU_MUL_EARLY_EXIT_EN
      S_DBL_M: state_d = alu_zr ? S_DONE : S_DBL_K;
`else
      S_DBL_M: state_d = S_DBL_K;
`endif
      // mask doubling to zero means bit 15 has been processed
      S_DBL_K: state_d = alu_zr ? S_DONE : S_TEST;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // x/y select and ADD-vs-AND; other ALU controls are never used
  always_comb begin
    alu_x = '0;
    alu_y = '0;
    alu_f = 1'b0;
    unique case (state_q)
      S_TEST: begin
        alu_x = mplier;
        alu_y = mask;
      end
      S_ADD: begin
        alu_x = acc;
        alu_y = mcand;
        alu_f = 1'b1;
      end
      S_DBL_M: begin
        alu_x = mcand;
        alu_y = mcand;
        alu_f = 1'b1;
      end
      S_DBL_K: begin
        alu_x = mask;
        alu_y = mask;
        alu_f = 1'b1;
      end
      default: begin
        alu_x = '0;
        alu_y = '0;
        alu_f = 1'b0;
      end
    endcase
  end

  assign alu_zx = 1'b0;
  assign alu_nx = 1'b0;
  assign alu_zy = 1'b0;
  assign alu_ny = 1'b0;
  assign alu_no = 1'b0;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mask    <= '0;
      product <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            mask   <= WIDTH'(1);
          end
        end
        S_ADD: acc <= alu_out;
        S_DBL_M: begin
          mcand <= alu_out;
`ifdef ALU_MUL_EARLY_EXIT_EN
          // remaining partial products are all zero
          if (alu_zr) product <= acc;
`endif
        end
        S_DBL_K: begin
          mask <= alu_out;
          // acc already holds this iteration's add, if any
          if (alu_zr) product <= acc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench for alu_mul_seq with a Hack ALU model.
// Expected products and latencies are hand-computed constants.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx;
  logic        alu_nx;
  logic        alu_zy;
  logic        alu_ny;
  logic        alu_f;
  logic        alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;

  int n_chk = 0;
  int n_fail = 0;
  int add_seen = 0;

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_zx  (alu_zx),
    .alu_nx  (alu_nx),
    .alu_zy  (alu_zy),
    .alu_ny  (alu_ny),
    .alu_f   (alu_f),
    .alu_no  (alu_no),
    .alu_out (alu_out),
    .alu_zr  (alu_zr)
  );

  always #5 clk = ~clk;

  // Hack ALU
  logic [15:0] hx, hy, ho;
  always_comb begin
    hx = alu_zx ? 16'h0 : alu_x;
    if (alu_nx) hx = ~hx;
    hy = alu_zy ? 16'h0 : alu_y;
    if (alu_ny) hy = ~hy;
    ho = alu_f ? (hx + hy) : (hx & hy);
    if (alu_no) ho = ~ho;
  end
  assign alu_out = ho;
  assign alu_zr  = (ho == 16'h0);

  // counts acc+mcand adds (the only ADD with unequal operands)
  always @(negedge clk) begin
    if (alu_f && (alu_x != alu_y)) add_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [15:0] ia, input logic [15:0] ib,
                        input bit hold);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    a = ~ia;
    b = ib ^ 16'h5a5a;
    chk("busy_on_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(output int lat, output int bad);
    logic [15:0] p0;
    lat = -1;
    bad = 0;
    p0 = product;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy || product !== p0) bad++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] ia,
                     input logic [15:0] ib, input logic [15:0] ep,
                     input int elat, output int adds);
    int lat, bad, a0;
    a0 = add_seen;
    launch(ia, ib, 1'b0);
    wait_done(lat, bad);
    adds = add_seen - a0;
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_prod"}, {16'd0, product}, {16'd0, ep});
    chk({tag, "_busy_hold"}, bad, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, {30'd0, done, busy}, 32'd0);
  endtask

  int adds, lat, bad, nd, nb;

  initial begin
    #12;
    chk("rst_flags", {29'd0, busy, done, 1'b0}, 32'd0);
    chk("rst_prod", {16'd0, product}, 32'd0);
    chk("rst_alu_xy", {alu_x, alu_y}, 32'd0);
    chk("rst_alu_ctl",
        {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("m11x3", 16'h0011, 16'h0003, 16'h0033, 50, adds);
    chk("m11x3_adds", adds, 2);
    chk("idle_alu", {alu_x, alu_y}, 32'd0);
    run("wrap", 16'h0100, 16'h0100, 16'h0000, 49, adds);
    run("ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 64, adds);
    run("b0", 16'h1234, 16'h0000, 16'h0000, 48, adds);
    chk("b0_adds", adds, 0);
    run("ffff2", 16'hFFFF, 16'hFFFF, 16'h0001, 64, adds);

    // abort mid-operation via async reset
    launch(16'h1234, 16'h5678, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_prod", {16'd0, product}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    nd = 0;
    nb = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
      if (busy) nb++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_no_busy", nb, 0);
    run("m5x7", 16'h0005, 16'h0007, 16'h0023, 51, adds);

    // start held across two operations
    launch(16'h0003, 16'h0005, 1'b1);
    wait_done(lat, bad);
    chk("hold1_lat", lat, 50);
    chk("hold1_prod", {16'd0, product}, 32'h000F);
    chk("hold1_busy", bad, 0);
    a = 16'h0007;
    b = 16'h0009;
    @(posedge clk);
    #1;
    chk("hold_gap", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    #1;
    chk("hold_reaccept", {31'd0, busy}, 32'd1);
    a = 16'h0000;
    b = 16'hFFFF;
    wait_done(lat, bad);
    start = 1'b0;
    chk("hold2_lat", lat, 50);
    chk("hold2_prod", {16'd0, product}, 32'h003F);
    chk("hold2_busy", bad, 0);
    nd = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("hold_one_done", nd, 0);
    chk("hold_idle", {31'd0, busy}, 32'd0);

`ifdef ALU_MUL_EARLY_EXIT_EN
    run("early", 16'h4000, 16'h0007, 16'hC000, 7, adds);
`else
    run("early", 16'h4000, 16'h0007, 16'hC000, 51, adds);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
